fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cqu_mips_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cqu_mips_pkg.sv
// Shared fetch-path constants and the buffered fetch entry layout.
package cqu_mips_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_INST_W = 32;
  localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = 32'h0040_0000;

  // One decoded-side entry: the address a word was fetched from plus the word.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_INST_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with synchronous flush and occupancy output.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  // A push into a full FIFO is only accepted when a pop frees a slot the same cycle.
  always_comb begin
    do_pop  = pop_i && (cnt_q != '0);
    do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
  end

  // Pointer and occupancy bookkeeping; flush wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word-aligned requests under a credit limit,
// tags in-order responses with their PC and buffers them for decode.
module fetch_unit
  import cqu_mips_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned INST_W = DEF_INST_W,
  parameter int unsigned DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_instr,
  input  logic              id_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] RESET_AL = {RESET_PC[ADDR_W-1:2], 2'b00};
  localparam logic [ADDR_W-1:0] WORD = ADDR_W'(4);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] pc_q, resp_pc_q, target;
  logic [CW-1:0]     out_q, drop_q, fifo_cnt;
  logic [CW:0]       inflight;
  logic              grant, rsp_ok, keep, pop, fifo_empty;
  entry_t            push_ent, head_ent;
  logic              unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];

  // Credit and handshake decode; responses with nothing outstanding are ignored.
  always_comb begin
    target   = {redirect_pc[ADDR_W-1:2], 2'b00};
    inflight = {1'b0, fifo_cnt} + {1'b0, out_q};
    imem_req = !rst && !redirect && (inflight < (CW+1)'(DEPTH));
    grant    = imem_req && imem_gnt;
    rsp_ok   = imem_rvalid && (out_q != '0);
    keep     = rsp_ok && !redirect && (drop_q == '0);
    pop      = if_valid && id_ready;
    push_ent = '{pc: resp_pc_q, instr: imem_rdata};
  end

  // Request/response PCs, outstanding count and stale-response drop counter.
  // On redirect every response still outstanding (minus one retiring now) is stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_AL;
      resp_pc_q <= RESET_AL;
      out_q     <= '0;
      drop_q    <= '0;
    end else begin
      out_q <= out_q + CW'(grant) - CW'(rsp_ok);
      if (redirect) begin
        pc_q      <= target;
        resp_pc_q <= target;
        drop_q    <= out_q - CW'(rsp_ok);
      end else begin
        if (grant) pc_q <= pc_q + WORD;
        if (keep)  resp_pc_q <= resp_pc_q + WORD;
        if (rsp_ok && (drop_q != '0)) drop_q <= drop_q - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect),
    .push_i  (keep),
    .din_i   (push_ent),
    .pop_i   (pop),
    .dout_o  (head_ent),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign imem_addr = pc_q;
  assign if_valid  = !fifo_empty;
  assign if_pc     = if_valid ? head_ent.pc    : '0;
  assign if_instr  = if_valid ? head_ent.instr : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a request/response queue model.
module tb_fetch_unit;

  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst, redirect, imem_req, imem_gnt, imem_rvalid, if_valid, id_ready;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, if_pc, if_instr;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W   (32),
    .INST_W   (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .id_ready    (id_ready)
  );

  // Memory-side requests in flight (stale = issued before a later redirect)
  typedef struct { logic [31:0] addr; int unsigned due; bit stale; } req_t;
  // Instructions waiting for decode
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  req_t        mq[$];
  ent_t        bq[$];
  logic [31:0] m_pc;
  int unsigned cyc = 0;
  int unsigned lat_lo = 1, lat_hi = 1;
  int          n_checks = 0, n_errors = 0;

  logic        s_req, s_valid, s_rv;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic apply_reset();
    rst = 1'b1; redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    id_ready = 1'b0; redirect_pc = '0; imem_rdata = '0;
    mq.delete(); bq.delete(); m_pc = RST_PC;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: drive inputs at negedge, compare against the model, advance the model.
  task automatic step(input bit gnt, input bit rdy, input bit redir,
                      input logic [31:0] tgt, input bit rv_en, input bit force_rv);
    bit   rv, e_req, e_valid, has_h;
    req_t h;
    imem_gnt = gnt; id_ready = rdy; redirect = redir; redirect_pc = tgt;
    rv = (rv_en && mq.size() > 0 && mq[0].due <= cyc) || force_rv;
    imem_rvalid = rv;
    imem_rdata  = (mq.size() > 0) ? mdata(mq[0].addr) : $urandom();
    #1;
    e_req   = !redir && (bq.size() + mq.size() < DEPTH);
    e_valid = bq.size() > 0;
    n_checks++;
    if (imem_req !== e_req) begin
      n_errors++; $display("FAIL imem_req cyc=%0d got %b expected %b", cyc, imem_req, e_req);
    end
    n_checks++;
    if (imem_addr !== m_pc) begin
      n_errors++; $display("FAIL imem_addr cyc=%0d got %h expected %h", cyc, imem_addr, m_pc);
    end
    n_checks++;
    if (if_valid !== e_valid) begin
      n_errors++; $display("FAIL if_valid cyc=%0d got %b expected %b", cyc, if_valid, e_valid);
    end
    if (e_valid) begin
      n_checks++;
      if (if_pc !== bq[0].pc || if_instr !== bq[0].instr) begin
        n_errors++;
        $display("FAIL if_data cyc=%0d got %h/%h expected %h/%h",
                 cyc, if_pc, if_instr, bq[0].pc, bq[0].instr);
      end
    end
    s_req = imem_req; s_addr = imem_addr; s_valid = if_valid;
    s_pc = if_pc; s_instr = if_instr; s_rv = rv;
    @(posedge clk);
    has_h = 1'b0;
    if (rv && mq.size() > 0) begin h = mq.pop_front(); has_h = 1'b1; end
    if (e_valid && rdy) void'(bq.pop_front());
    if (redir) begin
      bq.delete();
      foreach (mq[i]) mq[i].stale = 1'b1;
      m_pc = {tgt[31:2], 2'b00};
    end else begin
      if (has_h && !h.stale) bq.push_back('{pc: h.addr, instr: mdata(h.addr)});
      if (e_req && gnt) begin
        mq.push_back('{addr: m_pc, due: cyc + $urandom_range(lat_hi, lat_lo), stale: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_pc !== '0 || if_instr !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs got req=%b valid=%b pc=%h instr=%h expected 0/0/0/0",
               imem_req, if_valid, if_pc, if_instr);
    end
    n_checks++;
    if (imem_addr !== RST_PC) begin
      n_errors++; $display("FAIL reset_addr got %h expected %h", imem_addr, RST_PC);
    end
    apply_reset();
    // Spurious response with nothing outstanding must be ignored
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== RST_PC) begin
      n_errors++; $display("FAIL first_req got %b@%h expected 1@%h", s_req, s_addr, RST_PC);
    end
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (s_valid !== 1'b0) begin
      n_errors++; $display("FAIL spurious_rvalid got if_valid %b expected 0", s_valid);
    end
  endtask

  task automatic test_stream();
    logic        vv[8];
    logic [31:0] pp[8];
    apply_reset();
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
      vv[i] = s_valid; pp[i] = s_pc;
    end
    n_checks++;
    if (vv[0] !== 1'b0 || vv[1] !== 1'b0 || vv[2] !== 1'b1) begin
      n_errors++; $display("FAIL stream_latency got %b%b%b expected 001", vv[0], vv[1], vv[2]);
    end
    n_checks++;
    if (pp[2] !== 32'h0040_0000 || pp[3] !== 32'h0040_0004 || pp[4] !== 32'h0040_0008) begin
      n_errors++; $display("FAIL stream_pcs got %h %h %h expected 00400000 00400004 00400008",
                           pp[2], pp[3], pp[4]);
    end
    for (int i = 2; i < 8; i++) begin
      n_checks++;
      if (vv[i] !== 1'b1 || pp[i] !== RST_PC + 32'(4 * (i - 2))) begin
        n_errors++; $display("FAIL throughput[%0d] got %b@%h expected 1@%h",
                             i, vv[i], pp[i], RST_PC + 32'(4 * (i - 2)));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] hpc, hin, prev;
    bit          seen;
    hpc = bq[0].pc; hin = bq[0].instr;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if (s_valid !== 1'b1 || s_pc !== hpc || s_instr !== hin) begin
        n_errors++; $display("FAIL stall_hold[%0d] got %h/%h expected %h/%h", i, s_pc, s_instr, hpc, hin);
      end
    end
    n_checks++;
    if (s_req !== 1'b0) begin
      n_errors++; $display("FAIL stall_credit got imem_req %b expected 0", s_req);
    end
    seen = 1'b0; prev = '0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
      if (s_valid) begin
        n_checks++;
        if (s_pc !== (seen ? prev + 32'd4 : hpc)) begin
          n_errors++; $display("FAIL stall_release[%0d] got %h expected %h",
                               i, s_pc, seen ? prev + 32'd4 : hpc);
        end
        prev = s_pc; seen = 1'b1;
      end
    end
  endtask

  // Follows a redirect until the first new instruction appears; checks discards and target.
  task automatic expect_after_redirect(input string nm, input logic [31:0] tgt, input int exp_rv);
    int  rvs;
    bit  found;
    rvs = 0; found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
      if (i == 0) begin
        n_checks++;
        if (s_valid !== 1'b0) begin
          n_errors++; $display("FAIL %s_flush got if_valid %b expected 0", nm, s_valid);
        end
      end
      if (s_valid) found = 1'b1;
      else if (s_rv) rvs++;
    end
    n_checks++;
    if (!found || s_pc !== tgt || s_instr !== mdata(tgt)) begin
      n_errors++; $display("FAIL %s_target got %b %h/%h expected 1 %h/%h",
                           nm, found, s_pc, s_instr, tgt, mdata(tgt));
    end
    if (exp_rv >= 0) begin
      n_checks++;
      if (rvs != exp_rv) begin
        n_errors++; $display("FAIL %s_discards got %0d responses expected %0d", nm, rvs, exp_rv);
      end
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 10 && mq.size() < 2; i++)
      step(mq.size() < 2, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h0040_0100, 1'b0, 1'b0);
    expect_after_redirect("redirect", 32'h0040_0100, 3);
  endtask

  task automatic test_redirect_pop();
    int stale_n;
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 30 && !(i >= 8 && bq.size() > 0 && mq.size() > 1 && mq[0].due <= cyc); i++)
      step(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    stale_n = mq.size() - 1;
    step(1'b1, 1'b1, 1'b1, 32'h0040_0200, 1'b1, 1'b0);
    n_checks++;
    if (s_valid !== 1'b1 || s_rv !== 1'b1) begin
      n_errors++; $display("FAIL redirect_pop_setup got valid=%b rv=%b expected 1/1", s_valid, s_rv);
    end
    expect_after_redirect("redirect_pop", 32'h0040_0200, stale_n + 1);
  endtask

  task automatic test_wrap();
    lat_lo = 1; lat_hi = 1;
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
    expect_after_redirect("wrap", 32'hFFFF_FFFC, -1);
    step(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h0000_0000) begin
      n_errors++; $display("FAIL wrap_next got %b@%h expected 1@00000000", s_valid, s_pc);
    end
    step(1'b1, 1'b1, 1'b1, 32'h0040_0103, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (s_addr !== 32'h0040_0100) begin
      n_errors++; $display("FAIL unaligned_target got %h expected 00400100", s_addr);
    end
    expect_after_redirect("unaligned", 32'h0040_0100, -1);
  endtask

  task automatic random_steps(input int n);
    logic [31:0] tgt;
    for (int i = 0; i < n; i++) begin
      tgt = 32'h0040_0000 | ($urandom() & 32'h0000_0FFF);
      step($urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0, $urandom_range(39, 0) == 0,
           tgt, $urandom_range(3, 0) != 0, 1'b0);
    end
  endtask

  task automatic test_random_reset();
    apply_reset();
    lat_lo = 1; lat_hi = 5;
    random_steps(200);
    for (int i = 0; i < 50 && mq.size() == 0; i++)
      step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (mq.size() == 0) begin
      n_errors++; $display("FAIL midburst_setup got 0 outstanding expected >0");
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_pc !== '0 || if_instr !== '0 || imem_addr !== RST_PC) begin
      n_errors++;
      $display("FAIL midburst_reset got req=%b valid=%b pc=%h instr=%h addr=%h expected 0/0/0/0/%h",
               imem_req, if_valid, if_pc, if_instr, imem_addr, RST_PC);
    end
    @(negedge clk);
    apply_reset();
    step(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    n_checks++;
    if (s_req !== 1'b1 || s_addr !== RST_PC) begin
      n_errors++; $display("FAIL restart got %b@%h expected 1@%h", s_req, s_addr, RST_PC);
    end
    random_steps(250);
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    id_ready = 1'b0; redirect_pc = '0; imem_rdata = '0; m_pc = RST_PC;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_random_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
